// File: rtl/mpu6050_motion.sv
// mpu6050_motion: per-axis moving average, debounced shake pulse and tilt direction from raw accel samples.
// Latency: results registered 2 clock edges after the transfer edge; at most one sample per 3 cycles.
// Backpressure: SAMPLE_READY is low for the two processing cycles; VALID held meanwhile is not captured.
module mpu6050_motion #(
  parameter int AVG_LOG2  = 2,
  parameter int SHAKE_TH  = 4000,
  parameter int SHAKE_CNT = 3,
  parameter int TILT_TH   = 8000,
  parameter int HOLDOFF   = 25000000
) (
  input  logic               MCLK,
  input  logic               RESET,
  input  logic               SAMPLE_VALID,
  input  logic signed [15:0] ACCEL_X,
  input  logic signed [15:0] ACCEL_Y,
  input  logic signed [15:0] ACCEL_Z,
  output logic               SAMPLE_READY,
  output logic signed [15:0] AVG_X,
  output logic signed [15:0] AVG_Y,
  output logic signed [15:0] AVG_Z,
  output logic               AVG_VALID,
  output logic               SHAKE,
  output logic [1:0]         TILT_DIR
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 16 + AVG_LOG2;
  localparam int FW    = AVG_LOG2 + 1;
  localparam int CW    = $clog2(SHAKE_CNT + 1);
  localparam int HW    = $clog2(HOLDOFF + 1);

  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX   = CW'(SHAKE_CNT);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);
  localparam logic [16:0]   SHAKE_LIM = 17'(SHAKE_TH);
  localparam logic [16:0]   TILT_LIM  = 17'(TILT_TH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EVAL  = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   take;

  // captured sample
  logic signed [15:0] in_x, in_y, in_z;

  // averaging window
  logic signed [15:0]   hist_x [DEPTH];
  logic signed [15:0]   hist_y [DEPTH];
  logic signed [15:0]   hist_z [DEPTH];
  logic signed [SW-1:0] sum_x, sum_y, sum_z;
  logic [AVG_LOG2-1:0]  ptr;
  logic [FW-1:0]        fill;
  logic                 full;
  logic signed [15:0]   mean_x, mean_y, mean_z;

  // shake detection
  logic signed [15:0] prev_x, prev_y, prev_z;
  logic               have_prev;
  logic [CW-1:0]      hit_cnt, cnt_hit, cnt_nx;
  logic [HW-1:0]      holdoff;
  logic [16:0]        dx, dy, dz;
  logic               hit, fire;

  // tilt
  logic [1:0]  tilt_nx;
  logic [16:0] mag_x, mag_y;

  function automatic logic [16:0] sx17(input logic [15:0] v);
    return {v[15], v};
  endfunction

  function automatic logic [16:0] abs17(input logic [16:0] v);
    return v[16] ? (~v + 17'd1) : v;
  endfunction

  // FSM state register
  always_ff @(posedge MCLK) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next-state: accept in IDLE, then one ACCUM and one EVAL cycle, never stalls
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    case (state)
      S_IDLE: begin
        if (SAMPLE_VALID) begin
          take     = 1'b1;
          state_nx = S_ACCUM;
        end
      end
      S_ACCUM: state_nx = S_EVAL;
      S_EVAL:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // READY registered from the next state so it tracks IDLE exactly
  always_ff @(posedge MCLK) begin
    if (!RESET) SAMPLE_READY <= 1'b1;
    else        SAMPLE_READY <= (state_nx == S_IDLE);
  end

  // capture the raw sample on transfer
  always_ff @(posedge MCLK) begin
    if (!RESET) begin
      in_x <= '0;
      in_y <= '0;
      in_z <= '0;
    end else if (take) begin
      in_x <= ACCEL_X;
      in_y <= ACCEL_Y;
      in_z <= ACCEL_Z;
    end
  end

  // window update in ACCUM: swap oldest for newest, keep running sum and fill level
  always_ff @(posedge MCLK) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_x[i] <= '0;
        hist_y[i] <= '0;
        hist_z[i] <= '0;
      end
      sum_x <= '0;
      sum_y <= '0;
      sum_z <= '0;
      ptr   <= '0;
      fill  <= '0;
    end else if (state == S_ACCUM) begin
      sum_x       <= sum_x + SW'(in_x) - SW'(hist_x[ptr]);
      sum_y       <= sum_y + SW'(in_y) - SW'(hist_y[ptr]);
      sum_z       <= sum_z + SW'(in_z) - SW'(hist_z[ptr]);
      hist_x[ptr] <= in_x;
      hist_y[ptr] <= in_y;
      hist_z[ptr] <= in_z;
      ptr         <= ptr + AVG_LOG2'(1);
      if (fill != FILL_FULL) fill <= fill + FW'(1);
    end
  end

  // averages are the sum's upper 16 bits, i.e. an arithmetic shift (floor)
  always_comb begin
    full   = (fill == FILL_FULL);
    mean_x = sum_x[SW-1:AVG_LOG2];
    mean_y = sum_y[SW-1:AVG_LOG2];
    mean_z = sum_z[SW-1:AVG_LOG2];
  end

  // shake decision: 17-bit deltas, strict threshold, saturating run counter gated by holdoff
  always_comb begin
    dx = have_prev ? (sx17(in_x) - sx17(prev_x)) : 17'd0;
    dy = have_prev ? (sx17(in_y) - sx17(prev_y)) : 17'd0;
    dz = have_prev ? (sx17(in_z) - sx17(prev_z)) : 17'd0;
    hit = (abs17(dx) > SHAKE_LIM) || (abs17(dy) > SHAKE_LIM) || (abs17(dz) > SHAKE_LIM);
    cnt_hit = '0;
    if (hit) cnt_hit = (hit_cnt >= CNT_MAX) ? CNT_MAX : (hit_cnt + CW'(1));
    fire   = (cnt_hit == CNT_MAX) && (holdoff == '0);
    cnt_nx = fire ? '0 : cnt_hit;
  end

  // shake state: previous sample, run counter, free-running holdoff countdown and the pulse
  always_ff @(posedge MCLK) begin
    if (!RESET) begin
      prev_x    <= '0;
      prev_y    <= '0;
      prev_z    <= '0;
      have_prev <= 1'b0;
      hit_cnt   <= '0;
      holdoff   <= '0;
      SHAKE     <= 1'b0;
    end else begin
      SHAKE <= 1'b0;
      if (holdoff != '0) holdoff <= holdoff - HW'(1);
      if (state == S_EVAL) begin
        prev_x    <= in_x;
        prev_y    <= in_y;
        prev_z    <= in_z;
        have_prev <= 1'b1;
        hit_cnt   <= cnt_nx;
        if (fire) begin
          SHAKE   <= 1'b1;
          holdoff <= HOLD_LOAD;
        end
      end
    end
  end

  // tilt from the fresh averages: X wins over Y, magnitude compared in 17 bits
  always_comb begin
    mag_x = abs17(sx17(mean_x));
    mag_y = abs17(sx17(mean_y));
    if (mag_x > TILT_LIM)      tilt_nx = mean_x[15] ? 2'b10 : 2'b01;
    else if (mag_y > TILT_LIM) tilt_nx = 2'b11;
    else                       tilt_nx = 2'b00;
  end

  // publish averages and tilt in EVAL once the window is full
  always_ff @(posedge MCLK) begin
    if (!RESET) begin
      AVG_X     <= '0;
      AVG_Y     <= '0;
      AVG_Z     <= '0;
      AVG_VALID <= 1'b0;
      TILT_DIR  <= 2'b00;
    end else begin
      AVG_VALID <= 1'b0;
      if (state == S_EVAL && full) begin
        AVG_X     <= mean_x;
        AVG_Y     <= mean_y;
        AVG_Z     <= mean_z;
        AVG_VALID <= 1'b1;
        TILT_DIR  <= tilt_nx;
      end
    end
  end

endmodule

// File: tb/tb_mpu6050_motion.sv
// Directed bench for mpu6050_motion with small parameters (window 4, holdoff 100).
// Each feature task drives samples and compares outputs against hand-computed values.
module tb_mpu6050_motion;

  logic               MCLK = 1'b0;
  logic               RESET;
  logic               SAMPLE_VALID;
  logic signed [15:0] ACCEL_X, ACCEL_Y, ACCEL_Z;
  logic               SAMPLE_READY;
  logic signed [15:0] AVG_X, AVG_Y, AVG_Z;
  logic               AVG_VALID;
  logic               SHAKE;
  logic [1:0]         TILT_DIR;

  int errors = 0;
  int checks = 0;

  logic               got_vld, got_shake, got_early;
  logic signed [15:0] got_x, got_y, got_z;
  logic [1:0]         got_tilt;

  mpu6050_motion #(
    .AVG_LOG2 (2),
    .SHAKE_TH (4000),
    .SHAKE_CNT(3),
    .TILT_TH  (8000),
    .HOLDOFF  (100)
  ) dut (
    .MCLK        (MCLK),
    .RESET       (RESET),
    .SAMPLE_VALID(SAMPLE_VALID),
    .ACCEL_X     (ACCEL_X),
    .ACCEL_Y     (ACCEL_Y),
    .ACCEL_Z     (ACCEL_Z),
    .SAMPLE_READY(SAMPLE_READY),
    .AVG_X       (AVG_X),
    .AVG_Y       (AVG_Y),
    .AVG_Z       (AVG_Z),
    .AVG_VALID   (AVG_VALID),
    .SHAKE       (SHAKE),
    .TILT_DIR    (TILT_DIR)
  );

  always #5 MCLK = ~MCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic apply_reset();
    SAMPLE_VALID = 1'b0;
    RESET = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
  endtask

  // present a sample and return 1 time unit after the transfer edge
  task automatic xfer(input logic signed [15:0] x, input logic signed [15:0] y,
                      input logic signed [15:0] z);
    int   n;
    logic r, done;
    ACCEL_X = x;
    ACCEL_Y = y;
    ACCEL_Z = z;
    SAMPLE_VALID = 1'b1;
    n = 0;
    done = 1'b0;
    while (!done && n < 10) begin
      r = SAMPLE_READY;
      tick();
      if (r) done = 1'b1;
      n++;
    end
    SAMPLE_VALID = 1'b0;
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL xfer_timeout READY never high within %0d cycles", n);
    end
  endtask

  // transfer, then capture outputs in the cycle after the second edge
  task automatic send(input logic signed [15:0] x, input logic signed [15:0] y,
                      input logic signed [15:0] z);
    xfer(x, y, z);
    tick();
    got_early = AVG_VALID | SHAKE;
    tick();
    got_vld   = AVG_VALID;
    got_shake = SHAKE;
    got_x     = AVG_X;
    got_y     = AVG_Y;
    got_z     = AVG_Z;
    got_tilt  = TILT_DIR;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    SAMPLE_VALID = 1'b0;
    ACCEL_X = '0;
    ACCEL_Y = '0;
    ACCEL_Z = '0;
    repeat (5) tick();
    RESET = 1'b1;
    checks++;
    if (SAMPLE_READY !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b want 1", SAMPLE_READY);
    end
    checks++;
    if ({AVG_VALID, SHAKE, TILT_DIR} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {AVG_VALID, SHAKE, TILT_DIR});
    end
    checks++;
    if ({AVG_X, AVG_Y, AVG_Z} !== 48'd0) begin
      errors++; $display("FAIL reset_avg got %h want 0", {AVG_X, AVG_Y, AVG_Z});
    end
  endtask

  task automatic test_handshake();
    logic exp_r;
    apply_reset();
    ACCEL_X = '0;
    ACCEL_Y = '0;
    ACCEL_Z = '0;
    SAMPLE_VALID = 1'b1;
    for (int i = 0; i < 9; i++) begin
      exp_r = (i % 3 == 0);
      checks++;
      if (SAMPLE_READY !== exp_r) begin
        errors++; $display("FAIL ready_pattern cycle %0d got %b want %b", i, SAMPLE_READY, exp_r);
      end
      tick();
    end
    SAMPLE_VALID = 1'b0;
  endtask

  task automatic test_avg_ramp();
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      send(16'(i * 1000), 16'sd0, 16'sd0);
      checks++;
      if (got_vld !== 1'b0) begin
        errors++; $display("FAIL avg_early sample %0d AVG_VALID got %b want 0", i, got_vld);
      end
    end
    send(16'sd4000, 16'sd0, 16'sd0);
    checks++;
    if (got_vld !== 1'b1 || got_early !== 1'b0 || got_x !== 16'sd2500 || got_y !== 16'sd0) begin
      errors++;
      $display("FAIL avg_4th vld %b early %b X %0d Y %0d want 1 0 2500 0", got_vld, got_early, got_x, got_y);
    end
    send(16'sd5000, 16'sd0, 16'sd0);
    checks++;
    if (got_vld !== 1'b1 || got_x !== 16'sd3500) begin
      errors++; $display("FAIL avg_5th vld %b X %0d want 1 3500", got_vld, got_x);
    end
    // floor rounding: sum -1 must average to -1, not 0
    apply_reset();
    send(-16'sd1, 16'sd0, 16'sd0);
    send(16'sd0, 16'sd0, 16'sd0);
    send(16'sd0, 16'sd0, 16'sd0);
    send(16'sd0, 16'sd0, -16'sd3);
    checks++;
    if (got_vld !== 1'b1 || got_x !== -16'sd1 || got_z !== -16'sd1) begin
      errors++; $display("FAIL avg_floor vld %b X %0d Z %0d want 1 -1 -1", got_vld, got_x, got_z);
    end
    repeat (4) send(-16'sd1, 16'sd0, 16'sd0);
    checks++;
    if (got_x !== -16'sd1 || got_z !== 16'sd0) begin
      errors++; $display("FAIL avg_neg X %0d Z %0d want -1 0", got_x, got_z);
    end
  endtask

  task automatic test_shake();
    int xs[7] = '{0, 5000, 0, 5000, 0, 5000, 0};
    int ex[7] = '{0, 0, 0, 1, 0, 0, 0};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      send(16'(xs[i]), 16'sd0, 16'sd0);
      checks++;
      if (got_shake !== ex[i][0] || got_early !== 1'b0) begin
        errors++;
        $display("FAIL shake_seq sample %0d SHAKE got %b early %b want %0d", i, got_shake, got_early, ex[i]);
      end
      if (i == 3) begin
        tick();
        checks++;
        if (SHAKE !== 1'b0) begin
          errors++; $display("FAIL shake_width SHAKE got %b want 0 one cycle later", SHAKE);
        end
      end
    end
    repeat (100) tick();
    send(16'sd5000, 16'sd0, 16'sd0);
    checks++;
    if (got_shake !== 1'b1) begin
      errors++; $display("FAIL shake_after_holdoff SHAKE got %b want 1", got_shake);
    end
  endtask

  task automatic test_debounce();
    int xs[11] = '{0, 5000, 0, 100, 5100, 1100, 5100, 1100, 1100, 1100, 1100};
    int zs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 4001, 0, 4001};
    int ex[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      send(16'(xs[i]), 16'sd0, 16'(zs[i]));
      checks++;
      if (got_shake !== ex[i][0]) begin
        errors++; $display("FAIL debounce sample %0d SHAKE got %b want %0d", i, got_shake, ex[i]);
      end
    end
  endtask

  task automatic test_tilt();
    int xs[6]  = '{9000, -9000, 0, 9000, 8000, -8001};
    int ys[6]  = '{0, 0, -9000, 9000, 0, 0};
    int ex[6]  = '{1, 2, 3, 1, 0, 2};
    apply_reset();
    send(16'sd9000, 16'sd0, 16'sd0);
    send(16'sd9000, 16'sd0, 16'sd0);
    send(16'sd9000, 16'sd0, 16'sd0);
    checks++;
    if (got_tilt !== 2'b00) begin
      errors++; $display("FAIL tilt_unfilled got %b want 00", got_tilt);
    end
    send(16'sd9000, 16'sd0, 16'sd0);
    checks++;
    if (got_tilt !== 2'b01) begin
      errors++; $display("FAIL tilt_first got %b want 01", got_tilt);
    end
    for (int k = 1; k < 6; k++) begin
      repeat (4) send(16'(xs[k]), 16'(ys[k]), 16'sd0);
      checks++;
      if (got_tilt !== ex[k][1:0] || got_x !== 16'(xs[k]) || got_y !== 16'(ys[k])) begin
        errors++;
        $display("FAIL tilt_case %0d dir %b X %0d Y %0d want %0d %0d %0d", k, got_tilt, got_x, got_y,
                 ex[k], xs[k], ys[k]);
      end
    end
    repeat (4) send(16'sh8000, 16'sd0, 16'sd0);
    checks++;
    if (got_tilt !== 2'b10 || got_x !== 16'sh8000) begin
      errors++; $display("FAIL tilt_min dir %b X %0d want 10 -32768", got_tilt, got_x);
    end
  endtask

  task automatic test_midreset();
    logic seen;
    apply_reset();
    send(16'sd5000, 16'sd0, 16'sd0);
    send(16'sd0, 16'sd0, 16'sd0);
    send(16'sd5000, 16'sd0, 16'sd0);
    xfer(16'sd0, 16'sd0, 16'sd0);
    RESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | AVG_VALID | SHAKE;
      if (i == 1) RESET = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || SAMPLE_READY !== 1'b1) begin
      errors++; $display("FAIL midreset_discard pulse_seen %b READY %b want 0 1", seen, SAMPLE_READY);
    end
    send(16'sd0, 16'sd0, 16'sd0);
    checks++;
    if (got_vld !== 1'b0 || got_shake !== 1'b0) begin
      errors++; $display("FAIL midreset_s1 vld %b shake %b want 0 0", got_vld, got_shake);
    end
    send(16'sd5000, 16'sd0, 16'sd0);
    checks++;
    if (got_vld !== 1'b0 || got_shake !== 1'b0) begin
      errors++; $display("FAIL midreset_s2 vld %b shake %b want 0 0", got_vld, got_shake);
    end
    send(16'sd0, 16'sd0, 16'sd0);
    checks++;
    if (got_vld !== 1'b0 || got_shake !== 1'b0) begin
      errors++; $display("FAIL midreset_s3 vld %b shake %b want 0 0", got_vld, got_shake);
    end
    send(16'sd5000, 16'sd0, 16'sd0);
    checks++;
    if (got_vld !== 1'b1 || got_x !== 16'sd2500 || got_shake !== 1'b1) begin
      errors++; $display("FAIL midreset_s4 vld %b X %0d shake %b want 1 2500 1", got_vld, got_x, got_shake);
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_avg_ramp();
    test_shake();
    test_debounce();
    test_tilt();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
